mvd_mvp_sel: RTL

MVD_MVP_SEL -- requirements
Module: mvd_mvp_sel

---
 rtl/mvd_mvp_sel.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mvd_mvp_sel.sv
`default_nettype none
// ============================================================================
// Module   : mvd_mvp_sel
// Brief    : Picks the cheaper of two AMVP candidates for a final MV. It
//            produces the MVD and bit cost of the chosen candidate and keeps
//            a saturating running total of the selected bit costs.
// Revision : 1.0 - initial release
// ============================================================================
module mvd_mvp_sel #(
    parameter int FMV_WIDTH = 10,
    parameter int MVD_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start_i,
    input  logic [2*FMV_WIDTH-1:0] mv_i,
    input  logic [2*FMV_WIDTH-1:0] mvp0_i,
    input  logic [2*FMV_WIDTH-1:0] mvp1_i,
    input  logic                   mvp1_valid_i,
    input  logic                   clr_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   mvp_idx_o,
    output logic [2*MVD_WIDTH-1:0] mvd_o,
    output logic [6:0]             bits_o,
    output logic [15:0]            acc_o
);

    // Subtraction is done wide enough to hold both the sign-extended MV
    // operands and the MVD result, then trimmed to the MVD width.
    localparam int DIFF_W = (MVD_WIDTH > FMV_WIDTH + 1) ? MVD_WIDTH : FMV_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL0 = 2'd1,
        EVAL1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [2*FMV_WIDTH-1:0] mv_q;
    logic [2*FMV_WIDTH-1:0] mvp0_q;
    logic [2*FMV_WIDTH-1:0] mvp1_q;
    logic                   mvp1_valid_q;
    logic [6:0]             cost0_q;
    logic [2*MVD_WIDTH-1:0] mvd0_q;

    logic [2*FMV_WIDTH-1:0] mvp_cur;
    logic [MVD_WIDTH-1:0]   dx;
    logic [MVD_WIDTH-1:0]   dy;
    logic [6:0]             cost_cur;
    logic [2*MVD_WIDTH-1:0] mvd_cur;
    logic [16:0]            acc_sum;

    // Sign-extend both operands, subtract, keep the low MVD_WIDTH bits.
    function automatic logic [MVD_WIDTH-1:0] comp_diff(input logic [FMV_WIDTH-1:0] a,
                                                       input logic [FMV_WIDTH-1:0] b);
        logic [DIFF_W-1:0] ae;
        logic [DIFF_W-1:0] be;
        logic [DIFF_W-1:0] df;
        ae = DIFF_W'($signed(a));
        be = DIFF_W'($signed(b));
        df = ae - be;
        return df[MVD_WIDTH-1:0];
    endfunction

    // Cost of one component, computed on the doubled raw value with no
    // absolute value: any negative MVD costs the 63-bit escape.
    function automatic logic [6:0] comp_cost(input logic [MVD_WIDTH-1:0] d);
        logic [MVD_WIDTH:0] e;
        logic [6:0]         c;
        e = {d, 1'b0};
        c = 7'd1;
        for (int i = 1; i < MVD_WIDTH; i++) begin
            if (e[i]) c = 7'(2 * i + 1);
        end
        if (e[MVD_WIDTH]) c = 7'd63;
        return c;
    endfunction

    // Shared cost unit: candidate 1 in EVAL1, candidate 0 otherwise.
    always_comb begin
        mvp_cur  = (state == EVAL1) ? mvp1_q : mvp0_q;
        dx       = comp_diff(mv_q[FMV_WIDTH-1:0], mvp_cur[FMV_WIDTH-1:0]);
        dy       = comp_diff(mv_q[2*FMV_WIDTH-1:FMV_WIDTH], mvp_cur[2*FMV_WIDTH-1:FMV_WIDTH]);
        cost_cur = comp_cost(dx) + comp_cost(dy);
        mvd_cur  = {dx, dy};
    end

    // Evaluation FSM; result registers load on the transition into DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            mv_q         <= '0;
            mvp0_q       <= '0;
            mvp1_q       <= '0;
            mvp1_valid_q <= 1'b0;
            cost0_q      <= '0;
            mvd0_q       <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            mvp_idx_o    <= 1'b0;
            mvd_o        <= '0;
            bits_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        mv_q         <= mv_i;
                        mvp0_q       <= mvp0_i;
                        mvp1_q       <= mvp1_i;
                        mvp1_valid_q <= mvp1_valid_i;
                        busy_o       <= 1'b1;
                        state        <= EVAL0;
                    end
                end
                EVAL0: begin
                    cost0_q <= cost_cur;
                    mvd0_q  <= mvd_cur;
                    if (mvp1_valid_q) begin
                        state <= EVAL1;
                    end else begin
                        mvp_idx_o <= 1'b0;
                        mvd_o     <= mvd_cur;
                        bits_o    <= cost_cur;
                        done_o    <= 1'b1;
                        state     <= DONE;
                    end
                end
                EVAL1: begin
                    // Strict compare so that ties keep candidate 0.
                    if (cost_cur < cost0_q) begin
                        mvp_idx_o <= 1'b1;
                        mvd_o     <= mvd_cur;
                        bits_o    <= cost_cur;
                    end else begin
                        mvp_idx_o <= 1'b0;
                        mvd_o     <= mvd0_q;
                        bits_o    <= cost0_q;
                    end
                    done_o <= 1'b1;
                    state  <= DONE;
                end
                default: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign acc_sum = {1'b0, acc_o} + {10'd0, bits_o};

    // Bit accumulator: clear wins over add, clear-with-done restarts at bits_o.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_o <= '0;
        end else if (clr_i && done_o) begin
            acc_o <= {9'd0, bits_o};
        end else if (clr_i) begin
            acc_o <= '0;
        end else if (done_o) begin
            acc_o <= acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
        end
    end

endmodule
`default_nettype wire
